// File: rtl/i2c_init_sequencer.sv
// I2C/SCCB init sequencer: walks a {reg,data} table and issues one single-byte write per entry to an I2C master.
// Latency: first o_valid 3 cycles after i_start; FE-tagged entries insert data x 1 ms delays; FFFF ends the table.
// Backpressure: o_valid/o_wr_valid are held until their own ready handshakes, then the master's busy/idle cycle is tracked.
// Optional feature macro: I2C_SEQ_RETRY_EN (NACK retries up to MAX_RETRY per entry; otherwise the first NACK fails).
module i2c_init_sequencer #(
  parameter int         CLK_FREQ   = 25_000_000,
  parameter logic [6:0] SLAVE_ADDR = 7'h21,
  parameter bit         SCCB_MODE  = 1'b1,
  parameter int         ROM_AW     = 8,
  parameter int         MAX_RETRY  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_we,
  output logic              o_sccb_mode,
  output logic [6:0]        o_addr_slave,
  output logic [7:0]        o_addr_reg,
  output logic [3:0]        o_burst_num,
  output logic              o_wr_valid,
  output logic [7:0]        o_wr_data,
  input  logic              i_wr_ready,
  input  logic              i_cmd_ack,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  // Delay counter sized for the longest delay entry (255 ms).
  localparam int     TICKS_PER_MS = CLK_FREQ / 1000;
  localparam longint DLY_MAX      = longint'(255) * longint'(TICKS_PER_MS);
  localparam int     DLY_W        = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DELAY,
    S_FINISH,
    S_FAIL
  } state_t;

  state_t           r_state;
  logic [DLY_W-1:0] r_dly_cnt;
  logic [DLY_W-1:0] w_dly_load;
  logic             w_cmd_pending;
  logic             w_wr_pending;

`ifdef I2C_SEQ_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] r_retry;
`endif

  // Fixed command fields: every entry is a single-byte write to the same slave.
  assign o_we         = 1'b1;
  assign o_sccb_mode  = SCCB_MODE;
  assign o_addr_slave = SLAVE_ADDR;
  assign o_burst_num  = 4'd0;

  // Delay entries count data milliseconds at the core clock rate.
  assign w_dly_load = DLY_W'(i_rom_data[7:0]) * DLY_W'(TICKS_PER_MS);

  // A channel is still pending while its valid is up and this cycle's ready does not retire it.
  assign w_cmd_pending = o_valid & ~i_ready;
  assign w_wr_pending  = o_wr_valid & ~i_wr_ready;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_dly_cnt  <= '0;
      o_rom_addr <= '0;
      o_valid    <= 1'b0;
      o_wr_valid <= 1'b0;
      o_addr_reg <= 8'd0;
      o_wr_data  <= 8'd0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
      r_retry    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            o_done     <= 1'b0;
            o_error    <= 1'b0;
            o_rom_addr <= '0;
            o_busy     <= 1'b1;
`ifdef I2C_SEQ_RETRY_EN
            r_retry    <= '0;
`endif
            r_state    <= S_FETCH;
          end
        end
        // One cycle for the table read to return.
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          if (i_rom_data == 16'hFFFF) begin
            o_done  <= 1'b1;
            r_state <= S_FINISH;
          end else if (i_rom_data[15:8] == 8'hFE) begin
            if (w_dly_load == '0) begin
              // Zero-length delay: skip straight to the next entry.
              o_rom_addr <= o_rom_addr + ROM_AW'(1);
              r_state    <= S_FETCH;
            end else begin
              r_dly_cnt <= w_dly_load;
              r_state   <= S_DELAY;
            end
          end else begin
            o_addr_reg <= i_rom_data[15:8];
            o_wr_data  <= i_rom_data[7:0];
            o_valid    <= 1'b1;
            o_wr_valid <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (o_valid && i_ready) o_valid <= 1'b0;
          if (o_wr_valid && i_wr_ready) o_wr_valid <= 1'b0;
          if (!w_cmd_pending && !w_wr_pending) r_state <= S_WAIT_BUSY;
        end
        // Master drops ready while it runs the transfer.
        S_WAIT_BUSY: begin
          if (!i_ready) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_ready) begin
            if (i_cmd_ack) begin
              o_rom_addr <= o_rom_addr + ROM_AW'(1);
`ifdef I2C_SEQ_RETRY_EN
              r_retry    <= '0;
`endif
              r_state    <= S_FETCH;
            end else begin
`ifdef I2C_SEQ_RETRY_EN
              if (r_retry == RETRY_W'(MAX_RETRY)) begin
                o_error <= 1'b1;
                r_state <= S_FAIL;
              end else begin
                // Re-issue the same entry; reg/data are still latched.
                r_retry    <= r_retry + RETRY_W'(1);
                o_valid    <= 1'b1;
                o_wr_valid <= 1'b1;
                r_state    <= S_ISSUE;
              end
`else
              o_error <= 1'b1;
              r_state <= S_FAIL;
`endif
            end
          end
        end
        S_DELAY: begin
          if (r_dly_cnt <= DLY_W'(1)) begin
            r_dly_cnt  <= '0;
            o_rom_addr <= o_rom_addr + ROM_AW'(1);
            r_state    <= S_FETCH;
          end else begin
            r_dly_cnt <= r_dly_cnt - DLY_W'(1);
          end
        end
        S_FINISH: begin
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_FAIL: begin
          o_error <= 1'b1;
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer: table walk, delay timing, NACK handling, write-data backpressure, wrap and reset.
// Runs with CLK_FREQ=1 MHz (1 ms = 1000 cycles) and a 4-entry table.
// A task-driven master answers each command; a monitor counts command handshakes.
module tb_i2c_init_sequencer;
  localparam int AW = 2;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [AW-1:0] o_rom_addr;
  logic [15:0]   i_rom_data = 16'h0000;
  logic          o_valid;
  logic          i_ready;
  logic          o_we;
  logic          o_sccb_mode;
  logic [6:0]    o_addr_slave;
  logic [7:0]    o_addr_reg;
  logic [3:0]    o_burst_num;
  logic          o_wr_valid;
  logic [7:0]    o_wr_data;
  logic          i_wr_ready;
  logic          i_cmd_ack;
  logic          o_busy;
  logic          o_done;
  logic          o_error;

  int tests_run = 0;
  int failed    = 0;

  i2c_init_sequencer #(
    .CLK_FREQ  (1_000_000),
    .SLAVE_ADDR(7'h21),
    .SCCB_MODE (1'b1),
    .ROM_AW    (AW),
    .MAX_RETRY (3)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .o_rom_addr  (o_rom_addr),
    .i_rom_data  (i_rom_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_we        (o_we),
    .o_sccb_mode (o_sccb_mode),
    .o_addr_slave(o_addr_slave),
    .o_addr_reg  (o_addr_reg),
    .o_burst_num (o_burst_num),
    .o_wr_valid  (o_wr_valid),
    .o_wr_data   (o_wr_data),
    .i_wr_ready  (i_wr_ready),
    .i_cmd_ack   (i_cmd_ack),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous table with one cycle of read latency.
  logic [15:0] rom [4];
  always @(posedge i_clk) i_rom_data <= rom[o_rom_addr];

  // Command handshake counter.
  int cmd_cnt = 0;
  always @(posedge i_clk) if (o_valid && i_ready) cmd_cnt <= cmd_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (o_valid) found = 1'b1;
      else @(negedge i_clk);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 200 && !idle; k++) begin
      @(negedge i_clk);
      if (!o_busy) idle = 1'b1;
    end
    check(tag, idle, 1'b1);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Master side of one command: accept it, optionally stall write data, run a short busy phase, report ack.
  task automatic serve(input int wr_delay, input logic ack, output logic [7:0] r, output logic [7:0] d);
    bit found;
    i_ready    = 1'b1;
    i_wr_ready = (wr_delay == 0);
    wait_valid(found);
    check("cmd_seen", found, 1'b1);
    r = o_addr_reg;
    d = o_wr_data;
    if (!found) return;
    @(negedge i_clk);
    check("vld_drop", o_valid, 1'b0);
    if (wr_delay > 0) begin
      repeat (wr_delay - 1) @(negedge i_clk);
      check("wr_hold", o_wr_valid, 1'b1);
      check("no_reissue", o_valid, 1'b0);
      i_wr_ready = 1'b1;
      @(negedge i_clk);
    end
    check("wr_drop", o_wr_valid, 1'b0);
    i_wr_ready = 1'b0;
    i_ready    = 1'b0;
    repeat (3) @(negedge i_clk);
    i_cmd_ack = ack;
    i_ready   = 1'b1;
  endtask

  initial begin
    logic [7:0] r, d;
    int base, n;
    bit found;

    rom = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b1; i_wr_ready = 1'b0; i_cmd_ack = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Reset state and fixed command fields.
    check("rst_valid", o_valid, 1'b0);
    check("rst_wr_valid", o_wr_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_error", o_error, 1'b0);
    check("rst_rom_addr", o_rom_addr, 2'd0);
    check("rst_addr_reg", o_addr_reg, 8'h00);
    check("rst_wr_data", o_wr_data, 8'h00);
    check("we_const", o_we, 1'b1);
    check("sccb_mode", o_sccb_mode, 1'b1);
    check("slave_addr", o_addr_slave, 7'h21);
    check("burst_num", o_burst_num, 4'd0);

    // Two writes then end marker; first o_valid three cycles after start.
    rom = '{16'h1234, 16'h5678, 16'hFFFF, 16'hFFFF};
    base = cmd_cnt;
    i_wr_ready = 1'b1; i_cmd_ack = 1'b1;
    pulse_start();
    check("lat1_busy", o_busy, 1'b1);
    check("lat1_valid", o_valid, 1'b0);
    @(negedge i_clk);
    check("lat2_valid", o_valid, 1'b0);
    @(negedge i_clk);
    check("lat3_valid", o_valid, 1'b1);
    serve(0, 1'b1, r, d);
    check("c1_reg", r, 8'h12);
    check("c1_data", d, 8'h34);
    serve(0, 1'b1, r, d);
    check("c2_reg", r, 8'h56);
    check("c2_data", d, 8'h78);
    wait_idle("seq_idle");
    check("seq_done", o_done, 1'b1);
    check("seq_error", o_error, 1'b0);
    check("seq_rom_addr", o_rom_addr, 2'd2);
    check("seq_cmds", cmd_cnt - base, 2);

    // Write-data ready held low for 10 cycles after the command handshake.
    rom = '{16'hABCD, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    base = cmd_cnt;
    pulse_start();
    serve(10, 1'b1, r, d);
    check("bp_reg", r, 8'hAB);
    check("bp_data", d, 8'hCD);
    wait_idle("bp_idle");
    check("bp_cmds", cmd_cnt - base, 1);
    check("bp_done", o_done, 1'b1);

    // 2 ms delay entry at 1 MHz; a start pulse mid-delay must be ignored.
    rom = '{16'hFE02, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    base = cmd_cnt;
    pulse_start();
    n = 0;
    while (!o_done && n < 2200) begin
      @(negedge i_clk);
      n++;
      if (n == 100) i_start = 1'b1;
      if (n == 101) i_start = 1'b0;
    end
    check("dly_window", (n >= 1995 && n <= 2005), 1'b1);
    check("dly_no_cmd", cmd_cnt - base, 0);
    wait_idle("dly_idle");

    // NACK handling.
    rom = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFF};
`ifdef I2C_SEQ_RETRY_EN
    base = cmd_cnt;
    pulse_start();
    serve(0, 1'b0, r, d);
    check("rt1_reg", r, 8'h12);
    serve(0, 1'b0, r, d);
    check("rt2_reg", r, 8'h12);
    serve(0, 1'b1, r, d);
    check("rt3_reg", r, 8'h12);
    wait_idle("rt_idle");
    check("rt_cmds", cmd_cnt - base, 3);
    check("rt_done", o_done, 1'b1);
    check("rt_error", o_error, 1'b0);
    base = cmd_cnt;
    pulse_start();
    for (int k = 0; k < 4; k++) serve(0, 1'b0, r, d);
    wait_idle("rtx_idle");
    check("rtx_cmds", cmd_cnt - base, 4);
    check("rtx_error", o_error, 1'b1);
    check("rtx_done", o_done, 1'b0);
`else
    base = cmd_cnt;
    pulse_start();
    serve(0, 1'b0, r, d);
    check("nk_reg", r, 8'h12);
    wait_idle("nk_idle");
    repeat (5) @(negedge i_clk);
    check("nk_error", o_error, 1'b1);
    check("nk_done", o_done, 1'b0);
    check("nk_cmds", cmd_cnt - base, 1);
`endif

    // Address wrap: entry 0 is rewritten after first use, so the wrapped fetch ends the run.
    rom = '{16'h1234, 16'hFE00, 16'hFE00, 16'hFE00};
    base = cmd_cnt;
    pulse_start();
    check("start_clr_error", o_error, 1'b0);
    check("start_clr_done", o_done, 1'b0);
    serve(0, 1'b1, r, d);
    rom[0] = 16'hFFFF;
    wait_idle("wrap_idle");
    check("wrap_done", o_done, 1'b1);
    check("wrap_error", o_error, 1'b0);
    check("wrap_rom_addr", o_rom_addr, 2'd0);
    check("wrap_cmds", cmd_cnt - base, 1);

    // Reset while waiting for the master to finish, then restart from entry 0.
    rom = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    i_ready = 1'b1; i_wr_ready = 1'b1; i_cmd_ack = 1'b1;
    pulse_start();
    wait_valid(found);
    check("rs_cmd_seen", found, 1'b1);
    @(negedge i_clk);
    i_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    base = cmd_cnt;
    i_rst = 1'b1;
    @(negedge i_clk);
    check("rs_valid", o_valid, 1'b0);
    check("rs_wr_valid", o_wr_valid, 1'b0);
    check("rs_busy", o_busy, 1'b0);
    check("rs_done", o_done, 1'b0);
    check("rs_error", o_error, 1'b0);
    check("rs_rom_addr", o_rom_addr, 2'd0);
    check("rs_addr_reg", o_addr_reg, 8'h00);
    check("rs_wr_data", o_wr_data, 8'h00);
    i_rst = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    check("rs_no_cmd", cmd_cnt - base, 0);
    check("rs_idle_valid", o_valid, 1'b0);
    pulse_start();
    serve(0, 1'b1, r, d);
    check("rs_restart_reg", r, 8'h12);
    wait_idle("rs_idle");
    check("rs_restart_done", o_done, 1'b1);
    check("rs_restart_addr", o_rom_addr, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
